// File: rtl/uart_defs.sv
`default_nettype none
// ============================================================================
//  Module      : uart_defs (package)
//  Description : Shared UART definitions used by uart_recv and uart_send.
//                Provides the default line configuration, the per-bit
//                divider arithmetic and the receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_defs;

    // Computes the last value of the per-bit clock counter for a given clock
    // and line rate. One bit therefore lasts (result + 1) clocks.
    function automatic int baud_divider(input int clock_freq, input int baud_rate);
        return (clock_freq / baud_rate) - 1;
    endfunction

    // Computes the number of clocks from the start-bit edge to its midpoint.
    function automatic int baud_half(input int divider);
        return (divider + 1) / 2;
    endfunction

    // Default line configuration
    localparam int CLOCK_FREQ = 100_000_000;
    localparam int BAUD_RATE  = 9600;
    localparam int DIVIDER    = baud_divider(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF       = baud_half(DIVIDER);
    localparam int CNT_W      = $clog2(DIVIDER + 1);

    // Receiver state encoding
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Single-bit two-flop synchroniser for asynchronous inputs.
//                Both flops load RESET_VAL on reset so the synchronised
//                output starts from a known, inactive level.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input
//                o_q  - synchronised output (two clocks of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_recv.sv
`default_nettype none
// ============================================================================
//  Module      : uart_recv
//  Description : 8N1 UART receiver (LSB first, idle high). Recovers each
//                frame into a byte with a one-cycle valid strobe, flags a
//                low stop bit as a framing error and rejects start glitches.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous active-high reset
//                din        - asynchronous serial input, idle high
//                data       - last correctly received byte
//                valid      - one-cycle pulse, data just updated
//                frame_err  - one-cycle pulse, stop bit sampled low
//                busy       - high while a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_recv
    import uart_defs::*;
#(
    parameter int CLOCK_FREQ = uart_defs::CLOCK_FREQ,
    parameter int BAUD_RATE  = uart_defs::BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_divider = baud_divider(CLOCK_FREQ, BAUD_RATE);
    localparam int c_half    = baud_half(c_divider);
    localparam int c_cnt_w   = $clog2(c_divider + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_bit_end   = c_cnt_w'(c_divider);
    localparam logic [c_cnt_w-1:0] c_cnt_start_mid = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one       = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_din_s;
    logic r_din_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_din_sync (
        .clk (clk),
        .rst (rst),
        .i_d (din),
        .o_q (w_din_s)
    );

    // A falling edge needs the line to have been high the cycle before, so
    // a line that is simply held low never restarts reception.
    logic w_fall;
    assign w_fall = r_din_d & ~w_din_s;

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    rx_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
            r_din_d     <= 1'b1;
        end else begin
            r_din_d     <= w_din_s;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_busy  <= 1'b1;
                    end
                end

                // Re-check the line at the start-bit midpoint; a line that
                // has already returned high was only a glitch.
                RX_START: begin
                    if (r_cnt == c_cnt_start_mid) begin
                        r_cnt <= '0;
                        if (!w_din_s) begin
                            r_state <= RX_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= RX_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                // Counting from the start-bit midpoint, every full bit
                // period lands on the middle of the next data bit. The
                // register shifts right so the first bit (LSB) ends in [0].
                RX_DATA: begin
                    if (r_cnt == c_cnt_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {w_din_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                // Leaving at mid-stop-bit keeps half a bit of margin so a
                // start edge that follows immediately is not missed.
                RX_STOP: begin
                    if (r_cnt == c_cnt_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        r_busy  <= 1'b0;
                        if (w_din_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                default: begin
                    r_state <= RX_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_recv
//  Description : Self-checking bench for uart_recv. Frames are driven onto
//                din as timed bit waveforms; a frame-level model predicts
//                which frames yield a byte or a framing error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_recv;

    // 3.2 MHz / 100 kBd gives 32 clocks per bit (DIVIDER=31, HALF=16).
    localparam int TB_CLOCK_FREQ = 3_200_000;
    localparam int TB_BAUD_RATE  = 100_000;
    localparam int DIV           = TB_CLOCK_FREQ / TB_BAUD_RATE - 1;
    localparam int HALF          = (DIV + 1) / 2;
    localparam int CLK_HALF      = 50;
    localparam int CLK_PER       = 2 * CLK_HALF;
    localparam int BIT_T         = (DIV + 1) * CLK_PER;
    localparam int BIT_FAST      = BIT_T * 98 / 100;
    localparam int BIT_SLOW      = BIT_T * 102 / 100;
    localparam int LATENCY       = 2 + HALF + 9 * (DIV + 1) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    always #CLK_HALF clk = ~clk;

    uart_recv #(
        .CLOCK_FREQ (TB_CLOCK_FREQ),
        .BAUD_RATE  (TB_BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: counts strobes and records protocol violations.
    int         valid_seen   = 0;
    int         err_seen     = 0;
    int         busy_seen    = 0;
    int         protocol_bad = 0;
    logic       prev_pulse   = 1'b0;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_seen <= valid_seen + 1;
        if (frame_err === 1'b1) err_seen <= err_seen + 1;
        if (busy === 1'b1) busy_seen <= busy_seen + 1;
        if ((valid === 1'b1 && frame_err === 1'b1) ||
            (prev_pulse && (valid === 1'b1 || frame_err === 1'b1)))
            protocol_bad <= protocol_bad + 1;
        prev_pulse <= (valid === 1'b1) || (frame_err === 1'b1);
    end

    // Frame-level reference model
    int         exp_valid  = 0;
    int         exp_err    = 0;
    logic [7:0] model_data = 8'h00;

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bt);
        din = 1'b0;
        #bt;
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            #bt;
        end
        din = stop_bit;
        #bt;
        din = 1'b1;
        if (stop_bit) begin
            exp_valid++;
            model_data = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic check_frame(input string tag);
        check_value({tag, "_valid_count"}, valid_seen, exp_valid);
        check_value({tag, "_err_count"}, err_seen, exp_err);
        check_value({tag, "_data"}, data, model_data);
        check_value({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int          lat;
        int          busy_before;
        int          gap;
        int          bt;
        logic        stop_bit;
        logic        prev_err;
        logic [7:0]  b;
        logic [7:0]  byte_tbl [4];
        int          skew_tbl [3];

        byte_tbl = '{8'h3C, 8'hFF, 8'h00, 8'h5A};
        skew_tbl = '{BIT_FAST, BIT_T, BIT_SLOW};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset_data", data, 8'h00);
        check_value("reset_valid", valid, 1'b0);
        check_value("reset_frame_err", frame_err, 1'b0);
        check_value("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single frame with latency measurement
        fork
            send_frame(8'hA5, 1'b1, BIT_T);
            begin
                lat = 0;
                while (valid !== 1'b1 && lat < LATENCY + 50) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                if (lat >= LATENCY - 1 && lat <= LATENCY + 1) lat = LATENCY;
                check_value("latency", lat, LATENCY);
            end
        join
        check_frame("a5");

        // Back-to-back bytes with no idle gap
        for (int i = 0; i < 4; i++) begin
            send_frame(byte_tbl[i], 1'b1, BIT_T);
            check_frame("b2b");
        end

        // Start-bit glitch shorter than half a bit
        #(BIT_T);
        busy_before = busy_seen;
        din = 1'b0;
        #(8 * CLK_PER);
        din = 1'b1;
        #(2 * BIT_T);
        check_value("glitch_busy_pulsed", busy_seen > busy_before, 1'b1);
        check_frame("glitch");

        // Framing error, then a clean frame
        send_frame(8'h55, 1'b0, BIT_T);
        #(BIT_T);
        check_frame("frame_err");
        send_frame(8'h96, 1'b1, BIT_T);
        check_frame("after_err");

        // Reset during data bit 4 of 0xA5; the rest of the frame is abandoned
        #(BIT_T);
        b   = 8'hA5;
        din = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            din = b[i];
            #(BIT_T);
        end
        din = b[4];
        #(BIT_T / 2);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        din = 1'b1;
        check_value("midrst_data", data, 8'h00);
        check_value("midrst_valid", valid, 1'b0);
        check_value("midrst_frame_err", frame_err, 1'b0);
        check_value("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        model_data = 8'h00;
        #(12 * BIT_T);
        check_frame("midrst_quiet");
        send_frame(8'h3C, 1'b1, BIT_T);
        check_frame("midrst_next");

        // Baud skew of -2% and +2%
        #(BIT_T);
        send_frame(8'hC3, 1'b1, BIT_FAST);
        check_frame("skew_fast");
        #(BIT_T);
        send_frame(8'hC3, 1'b1, BIT_SLOW);
        check_frame("skew_slow");

        // Randomised frames: byte, stop bit, bit period, gap and phase
        prev_err = 1'b0;
        for (int n = 0; n < 24; n++) begin
            gap = $urandom_range(0, 2 * BIT_T);
            // After a low stop bit the line must go high again before a
            // new start edge can exist.
            if (prev_err && gap < BIT_T) gap = BIT_T;
            if (gap > 0) #(gap);
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 5) != 0);
            bt       = skew_tbl[$urandom_range(0, 2)];
            send_frame(b, stop_bit, bt);
            check_frame("random");
            prev_err = ~stop_bit;
        end

        #(2 * BIT_T);
        check_frame("final");
        check_value("strobe_protocol", protocol_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- Serial-to-parallel UART receiver; consumes the `dout` line produced by `uart_send` (8N1, LSB first, idle high).
- Recovers each frame into a byte plus a one-cycle `valid` strobe for downstream logic.
- Flags stop-bit (framing) errors and rejects start-bit glitches.
- Sits at the chip's RX pin and is also used in loopback against `uart_send` in simulation.

Parameters:
- CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits per second.
- DIVIDER, CLOCK_FREQ/BAUD_RATE-1 (10415), last value of the per-bit clock counter; one bit = DIVIDER+1 clocks.
- HALF, (DIVIDER+1)/2 (5208), clocks from the start-bit edge to the start-bit midpoint.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  asynchronous serial input; idle high.
- data  out  8  last correctly received byte.
- valid  out  1  one-cycle pulse: `data` was just updated with a good frame.
- frame_err  out  1  one-cycle pulse: stop bit was sampled low; frame discarded.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: synchronous, active-high, one clock; single reset branch clears all state. Reset values:
  - data=8'h00, valid=0, frame_err=0, busy=0.
  - state=IDLE, counters=0.
  - Both synchroniser flops and the edge-detect flop = 1.
- Input conditioning:
  - din passes through a 2-FF synchroniser to give din_s.
  - din_d is din_s delayed by one clock, used for edge detection.
  - All decisions use din_s only.
- State machine: IDLE, START, DATA, STOP; cnt is 14 bits, idx is 3 bits.
  - IDLE: on a falling edge (din_d=1, din_s=0) go to START with cnt=0. A line that is merely held low does not retrigger.
  - START: cnt increments each clock. At cnt==HALF-1, sample din_s:
    - din_s=0: go to DATA, cnt=0, idx=0.
    - din_s=1: glitch; return to IDLE with no output pulse.
  - DATA: at cnt==DIVIDER, shift din_s into shift[7] (shift register moves right, so LSB arrives first), cnt=0, idx+1. After idx==7 is sampled, go to STOP. Otherwise cnt increments.
  - STOP: at cnt==DIVIDER, sample din_s and return to IDLE the next cycle:
    - din_s=1: data<=shift, valid=1 for exactly one cycle.
    - din_s=0: frame_err=1 for exactly one cycle; data unchanged.
- Every sample lands near mid-bit: HALF + k*(DIVIDER+1) clocks after the start edge.
- Latency: valid rises 2 + HALF + 9*(DIVIDER+1) + 1 clocks after din first goes low, ±1 clock for synchroniser phase. At defaults this is 98,955 clocks.
- valid and frame_err are registered, mutually exclusive, and never high for two consecutive cycles.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so the next start edge is caught with no dead time.
- Baud tolerance: frames with bit period within ±2% of nominal must be received correctly.
- Reset mid-frame: the frame in progress is aborted silently (no valid, no frame_err). Reception resumes on the next falling edge after rst deasserts.
- A din change in the same cycle as a sample point is absorbed by the synchroniser; no special case is required.

Decomposition:
- Shared package/header `uart_defs`, also adopted by `uart_send`:
  - CLOCK_FREQ, BAUD_RATE, DIVIDER, HALF.
  - Counter width, computed as $clog2(DIVIDER+1).
  - RX state encodings IDLE/START/DATA/STOP.
- One natural sub-module: `sync_2ff` (1-bit two-flop synchroniser with reset value parameter, here 1), reusable for other async inputs.

Test Plan:
- Loopback via uart_send, valid pulse with 8'hA5 → exactly one valid pulse, data=8'hA5, frame_err stays 0, busy low afterwards.
- Back-to-back bytes 8'h3C, 8'hFF, 8'h00, 8'h5A with no idle gap → four valid pulses, data matches each in order, no frame_err.
- Glitch: din low for 1000 clocks (< HALF), then high → FSM returns to IDLE, no valid, no frame_err, busy pulses then clears.
- Framing error: hand-driven frame 0x55 with stop bit 0 → one frame_err pulse, valid 0, data retains previous value. Next clean 0x96 frame → valid, data=0x96.
- Reset mid-frame: assert rst for 2 clocks during data bit 4 of 0xA5 → no pulse, all outputs at reset values. Following 0x3C frame → valid, data=0x3C.
- Baud skew: drive 0xC3 with bit period DIVIDER+1 ±2% (10208 and 10624 clocks) → both received correctly; valid timing within the latency bound ±2% of frame length.
